// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the single-issue RISC-V core:
//   - funct3 access-size encodings for loads and stores
//   - major opcode constants used by the control decoder
//   - state encoding of the memory access unit FSM
//   - isMisaligned(): natural-alignment check for a given access size
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

   // funct3 access sizes (bit 2 selects zero-extension for loads)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Major opcodes decoded by the main control unit
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Memory access unit FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mau_state_e;

   // Byte accesses are always aligned, halfwords need addr[0]=0 and anything
   // wider is treated as a word needing addr[1:0]=0 (matches the lane logic).
   function automatic logic isMisaligned(input logic [1:0] sizeBits,
                                         input logic [1:0] addrLo);
      case (sizeBits)
         2'b00:   isMisaligned = 1'b0;
         2'b01:   isMisaligned = addrLo[0];
         default: isMisaligned = (addrLo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
// Purely combinational lane logic for the memory stage.
//   i_funct3     access size / sign (riscv_pkg F3_* encodings)
//   i_addr_lo    low two address bits selecting the byte lane
//   i_store_data rs2 value of a store
//   i_rdata      word returned by the data memory
//   o_be         store byte enables
//   o_wdata      store data replicated across all lanes of its size
//   o_load_data  selected load lane, sign- or zero-extended
// ---------------------------------------------------------------------------
module load_store_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr_lo,
   input  logic [XLEN-1:0] i_store_data,
   input  logic [XLEN-1:0] i_rdata,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_load_data
);

   logic [XLEN-1:0] w_shifted;

   // Move the addressed lane down to bit 0 so extension works on one place.
   assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

   // Store side: replicating the data lets memory pick it up from whichever
   // lane the byte enables select.
   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_store_data;
      case (i_funct3[1:0])
         F3_B[1:0]: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {(XLEN/8){i_store_data[7:0]}};
         end
         F3_H[1:0]: begin
            o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata = {(XLEN/16){i_store_data[15:0]}};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_store_data;
         end
      endcase
   end

   // Load side: funct3[2] selects zero-extension (BU/HU).
   always_comb begin
      o_load_data = i_rdata;
      case (i_funct3[1:0])
         F3_B[1:0]: o_load_data = i_funct3[2] ?
                                  {{(XLEN-8){1'b0}}, w_shifted[7:0]} :
                                  {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
         F3_H[1:0]: o_load_data = i_funct3[2] ?
                                  {{(XLEN-16){1'b0}}, w_shifted[15:0]} :
                                  {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         default:   o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-stage access unit: runs one data-memory transaction per load/store
// over a req/gnt/rvalid handshake, stalls the pipeline meanwhile and emits a
// registered writeback record.
//   clk, rstn                        clock, async active-low reset
//   ex_valid, mem_read, mem_write,
//   mem_to_reg, reg_write, funct3,
//   alu_result, store_data, rd       instruction from the execute stage
//   stall                            combinational upstream hold
//   dmem_req/we/addr/wdata/be        registered request to data memory
//   dmem_gnt, dmem_rvalid, dmem_rdata  memory grant and read response
//   wb_valid/reg_write/rd/data       registered writeback record
//   misalign, timeout                error pulses aligned with wb_valid
// ---------------------------------------------------------------------------
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            ex_valid,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_to_reg,
   input  logic            reg_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] store_data,
   input  logic [4:0]      rd,
   output logic            stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic            wb_reg_write,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misalign,
   output logic            timeout
);

   mau_state_e      r_state, w_nextState;
   logic [XLEN-1:0] r_addr, r_wdata, r_wbData;
   logic [2:0]      r_funct3;
   logic [4:0]      r_rd, r_wbRd;
   logic [3:0]      r_be;
   logic [7:0]      r_waitCnt;
   logic            r_memToReg, r_regWrite, r_we, r_dmemReq;
   logic            r_wbValid, r_wbRegWrite, r_misalign, r_timeout;

   logic            w_isMem, w_misaligned, w_accept, w_cntHit, w_stall, w_abort;
   logic [2:0]      w_alignFunct3;
   logic [1:0]      w_alignAddrLo;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_loadData;

   assign w_isMem      = mem_read | mem_write;
   assign w_misaligned = isMisaligned(funct3[1:0], alu_result[1:0]);
   assign w_accept     = (r_state == IDLE) && ex_valid && w_isMem && !w_misaligned;
   assign w_cntHit     = (r_waitCnt == 8'(MAX_WAIT - 1));

   // One lane aligner serves both directions: store lanes are needed only at
   // acceptance (IDLE, live inputs), load extraction only in WAIT (latched).
   assign w_alignFunct3 = (r_state == IDLE) ? funct3 : r_funct3;
   assign w_alignAddrLo = (r_state == IDLE) ? alu_result[1:0] : r_addr[1:0];

   load_store_align #(.XLEN(XLEN)) u_align (
      .i_funct3     (w_alignFunct3),
      .i_addr_lo    (w_alignAddrLo),
      .i_store_data (store_data),
      .i_rdata      (dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_load_data  (w_loadData)
   );

   // Next-state and stall. Completion (store grant, load rvalid) and abort
   // release the stall in the same cycle so the pipeline advances at the edge.
   always_comb begin
      w_nextState = r_state;
      w_stall     = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = REQ;
               w_stall     = 1'b1;
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               w_nextState = r_we ? IDLE : WAIT;
               w_stall     = !r_we;
            end else if (w_cntHit) begin
               w_nextState = IDLE;
               w_abort     = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               w_nextState = IDLE;
            end else if (w_cntHit) begin
               w_nextState = IDLE;
               w_abort     = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Gated by reset so stall reads 0 while rstn is low, whatever ex_valid does.
   assign stall = rstn & w_stall;

   // State, timeout counter and the request registers. The request fields are
   // captured once at acceptance so they stay stable until the grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_waitCnt  <= 8'd0;
         r_dmemReq  <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= 4'b0;
         r_we       <= 1'b0;
         r_funct3   <= 3'b0;
         r_rd       <= 5'd0;
         r_memToReg <= 1'b0;
         r_regWrite <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_dmemReq <= (w_nextState == REQ);
         if (w_accept || ((r_state == REQ) && dmem_gnt)) begin
            r_waitCnt <= 8'd0;
         end else if ((r_state == REQ) || (r_state == WAIT)) begin
            r_waitCnt <= r_waitCnt + 8'd1;
         end
         if (w_accept) begin
            r_addr     <= alu_result;
            r_wdata    <= w_wdata;
            r_be       <= w_be;
            r_we       <= mem_write;
            r_funct3   <= funct3;
            r_rd       <= rd;
            r_memToReg <= mem_to_reg;
            r_regWrite <= reg_write & ~mem_write;
         end
      end
   end

   // Writeback record: every source produces a one-cycle pulse; the flags
   // default low each cycle and only the completing event sets them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wbValid    <= 1'b0;
         r_wbRegWrite <= 1'b0;
         r_wbRd       <= 5'd0;
         r_wbData     <= '0;
         r_misalign   <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_wbValid    <= 1'b0;
         r_wbRegWrite <= 1'b0;
         r_misalign   <= 1'b0;
         r_timeout    <= 1'b0;
         if ((r_state == IDLE) && ex_valid && !w_isMem) begin
            r_wbValid    <= 1'b1;
            r_wbRegWrite <= reg_write;
            r_wbRd       <= rd;
            r_wbData     <= alu_result;
         end else if ((r_state == IDLE) && ex_valid && w_misaligned) begin
            r_wbValid  <= 1'b1;
            r_misalign <= 1'b1;
            r_wbRd     <= rd;
            r_wbData   <= alu_result;
         end else if ((r_state == REQ) && dmem_gnt && r_we) begin
            r_wbValid <= 1'b1;
            r_wbRd    <= r_rd;
            r_wbData  <= r_addr;
         end else if ((r_state == WAIT) && dmem_rvalid) begin
            r_wbValid    <= 1'b1;
            r_wbRegWrite <= r_regWrite;
            r_wbRd       <= r_rd;
            r_wbData     <= r_memToReg ? w_loadData : r_addr;
         end else if (w_abort) begin
            r_wbValid <= 1'b1;
            r_timeout <= 1'b1;
            r_wbRd    <= r_rd;
            r_wbData  <= r_addr;
         end
      end
   end

   assign dmem_req     = r_dmemReq;
   assign dmem_we      = r_we;
   assign dmem_addr    = {r_addr[XLEN-1:2], 2'b00};
   assign dmem_wdata   = r_wdata;
   assign dmem_be      = r_be;
   assign wb_valid     = r_wbValid;
   assign wb_reg_write = r_wbRegWrite;
   assign wb_rd        = r_wbRd;
   assign wb_data      = r_wbData;
   assign misalign     = r_misalign;
   assign timeout      = r_timeout;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit for the single-issue RISC-V core. It consumes the memory and writeback control signals produced by the main control decoder (`mem_read`, `mem_write`, `mem_to_reg`, `reg_write`) and executes the resulting data-memory transaction over a request/grant/response handshake. It stalls the pipeline while the transaction is in flight and delivers a registered writeback record to the register file.

## Interface
- `XLEN`, 32, datapath width.
- `MAX_WAIT`, 255, cycles allowed in REQ or WAIT before the access is aborted; range 1..255.

- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  an instruction is present at the unit's input this cycle.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`  in  1 each  control-decoder outputs for that instruction.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_result`  in  XLEN  effective address, or the result for non-memory instructions.
- `store_data`  in  XLEN  rs2 value for stores.
- `rd`  in  5  destination register.
- `stall`  out  1  holds the upstream pipeline; combinational.
- `dmem_req`, `dmem_we`  out  1  request and write-enable, registered.
- `dmem_addr`  out  XLEN  word-aligned address, `{alu_result[XLEN-1:2],2'b00}`.
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_gnt`, `dmem_rvalid`  in  1  grant and read-response valid.
- `dmem_rdata`  in  XLEN  read data, qualified by `dmem_rvalid`.
- `wb_valid`, `wb_reg_write`  out  1  writeback record valid and its register-write enable.
- `wb_rd`  out  5.
- `wb_data`  out  XLEN.
- `misalign`, `timeout`  out  1  one-cycle error pulses, aligned with `wb_valid`.

## Operation
- FSM states:
  - IDLE: `ex_valid` with `mem_read|mem_write` and an aligned address latches address, data, size, `rd` and the control bits, then moves to REQ. `stall`=1 in this cycle.
  - REQ: `dmem_req`=1, `stall`=1 until `dmem_gnt`.
    - Store granted: writeback is issued, `stall`=0 in the grant cycle, next state IDLE.
    - Load granted: next state WAIT.
  - WAIT: `stall`=1 until `dmem_rvalid`. In the `rvalid` cycle `stall`=0, the load data is captured, writeback is issued, next state IDLE.
- Non-memory instruction in IDLE: no stall. The next cycle carries `wb_valid`=1, `wb_data`=`alu_result`, `wb_reg_write`=`reg_write`.
- `mem_read` and `mem_write` both set: treated as a store; the read is ignored.
- Misalignment: H/HU/SH with `addr[0]`≠0, or W/SW with `addr[1:0]`≠0.
  - No request is issued and there is no stall.
  - The next cycle carries `misalign`=1 and `wb_valid`=1 with `wb_reg_write`=0.
- Stores:
  - B: `be`=0001<<`addr[1:0]`, byte replicated ×4.
  - H: `be`=0011<<{`addr[1]`,0}, half replicated ×2.
  - W: `be`=1111.
  - `wb_reg_write`=0.
- Loads: select the lane by `addr[1:0]`; sign-extend for B/H, zero-extend for BU/HU. `wb_data` = `mem_to_reg` ? extracted data : `alu_result`.
- Timeout: an 8-bit counter clears on entry to REQ and on `dmem_gnt`, and increments in REQ and WAIT.
  - At `MAX_WAIT`: abort, `stall`=0 that cycle, next state IDLE.
  - The next cycle carries `timeout`=1 and `wb_valid`=1 with `wb_reg_write`=0.
  - A late `dmem_rvalid` or `dmem_gnt` while in IDLE is ignored.
- `dmem_gnt` while in WAIT is ignored. `dmem_rvalid` while in REQ is ignored.

## Timing
- Reset: state IDLE, counter 0, and every output 0, including `stall`. `dmem_req` drops asynchronously. A transaction interrupted by reset produces no writeback.
- Latency from acceptance (cycle 0), with zero-wait memory:
  - Store: `dmem_req` in cycle 1, grant in cycle 1, `wb_valid` in cycle 2.
  - Load: `req` and `gnt` in cycle 1, `rvalid` in cycle 2, `wb_valid` in cycle 3.
- `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are stable from `dmem_req` rising until the grant.
- `wb_*`, `misalign` and `timeout` are registered. Each is a single-cycle pulse unless back-to-back instructions assert it again.
- A new instruction can be accepted in the cycle after completion: back-to-back memory operations give one IDLE cycle between requests.

## Structure
- Shared package `riscv_pkg` holds:
  - the funct3 size constants;
  - the opcode constants used by the control decoder;
  - the FSM state enum: IDLE, REQ, WAIT.
- Sub-module `load_store_align` is purely combinational. It generates the store byte-enables and replicated write data, and performs the load lane select and sign/zero extension.
- The top level holds the FSM, the timeout counter and the writeback registers.

## Test plan
- ADD (`alu_result`=0x1234, `reg_write`=1, `rd`=5) → no stall; next cycle `wb_valid`=1, `wb_rd`=5, `wb_data`=0x1234.
- SB at 0x1003, `store_data`=0xAB, `gnt` on the first REQ cycle → `dmem_addr`=0x1000, `be`=1000, `wdata`=0xABABABAB; `stall` high for 1 cycle; `wb_reg_write`=0.
- LH at 0x2002 with `rdata`=0x8001_7FFF and `rvalid` 3 cycles after `gnt` → `wb_data`=0xFFFF_8001; `stall` deasserts in the `rvalid` cycle; LHU on the same stimulus → 0x0000_8001.
- LW at 0x2001 → no `dmem_req`, `misalign`=1 for one cycle, `wb_reg_write`=0.
- LW with `MAX_WAIT`=4 and `gnt` held low → abort after 4 REQ cycles, `timeout` pulse, a later `rvalid` is ignored, and the next instruction is accepted normally.
- Reset asserted while in WAIT → `dmem_req`/`stall` drop immediately, no writeback; after release a store completes normally.
